// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller.
// Walks the player through title, play, and the event screens: died,
// level-up, world-up, game over and win. It also drives the lives LEDs,
// the tune selection and the object-reset mux.
// Every output is a register, so an input sampled in cycle N shows on the
// outputs in cycle N+1.
// Optional feature: define GAME_CHEAT_SKIP_EN to add the cheat_skip input.
// A rising edge on cheat_skip during play counts as a level completion.
module game_sequencer #(
    parameter int NUM_WORLDS       = 3,
    parameter int LEVELS_PER_WORLD = 4,
    parameter int MAX_LIVES        = 5,
    parameter int LVL_W            = 3,
    parameter int WLD_W            = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 continue_btn,
    input  logic                 start_btn,
    input  logic                 player_dead,
    input  logic                 level_complete,
    input  logic                 seq_end,
`ifdef GAME_CHEAT_SKIP_EN
    input  logic                 cheat_skip,
`endif
    output logic [LVL_W-1:0]     level,
    output logic [WLD_W-1:0]     world,
    output logic [2:0]           screen,
    output logic [MAX_LIVES-1:0] lives,
    output logic                 player_disable,
    output logic                 reset_select,
    output logic [2:0]           audio_select,
    output logic                 audio_enable
);

    // Screen codes shown on the display
    localparam logic [2:0] SCR_TITLE = 3'd0;
    localparam logic [2:0] SCR_PLAY  = 3'd1;
    localparam logic [2:0] SCR_LOSE  = 3'd2;
    localparam logic [2:0] SCR_WIN   = 3'd3;
    localparam logic [2:0] SCR_LVL   = 3'd4;
    localparam logic [2:0] SCR_WLD   = 3'd5;
    localparam logic [2:0] SCR_DIED  = 3'd6;

    // Tune codes for the audio player
    localparam logic [2:0] AUD_NONE  = 3'd0;
    localparam logic [2:0] AUD_DEATH = 3'd1;
    localparam logic [2:0] AUD_LEVEL = 3'd2;
    localparam logic [2:0] AUD_WORLD = 3'd3;
    localparam logic [2:0] AUD_OVER  = 3'd4;
    localparam logic [2:0] AUD_WIN   = 3'd5;

    localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(LEVELS_PER_WORLD - 1);
    localparam logic [WLD_W-1:0] LAST_WORLD = WLD_W'(NUM_WORLDS - 1);

    typedef enum logic [2:0] {
        S_TITLE,
        S_PLAY,
        S_DIED,
        S_LVL_UP,
        S_WLD_UP,
        S_GAMEOVER,
        S_WIN
    } state_t;

    state_t                 r_state;
    // In an event state: 1 while the tune plays, 0 while waiting for continue
    logic                   r_tune;
    logic [LVL_W-1:0]       r_level;
    logic [WLD_W-1:0]       r_world;
    logic [MAX_LIVES-1:0]   r_lives;
    logic [2:0]             r_screen;
    logic                   r_player_disable;
    logic                   r_reset_select;
    logic [2:0]             r_audio_select;
    logic                   r_audio_enable;

    // The lives bus is a thermometer code, so losing a life is a right shift.
    // The shifted value is all zeros exactly when the last life has gone.
    logic [MAX_LIVES-1:0]   w_lives_dec;
    logic                   w_last_life;
    logic                   w_complete;

    assign w_lives_dec = r_lives >> 1;
    assign w_last_life = (w_lives_dec == '0);

`ifdef GAME_CHEAT_SKIP_EN
    logic r_cheat_prev;

    // Remember last cycle's cheat_skip level, so only its rising edge counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cheat_prev <= 1'b0;
        end else begin
            r_cheat_prev <= cheat_skip;
        end
    end

    assign w_complete = level_complete | (cheat_skip & ~r_cheat_prev);
`else
    assign w_complete = level_complete;
`endif

    // Game flow FSM; every output is loaded in the same cycle as its state change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_TITLE;
            r_tune           <= 1'b0;
            r_level          <= '0;
            r_world          <= '0;
            r_lives          <= '1;
            r_screen         <= SCR_TITLE;
            r_player_disable <= 1'b1;
            r_reset_select   <= 1'b1;
            r_audio_enable   <= 1'b0;
            r_audio_select   <= AUD_NONE;
        end else begin
            case (r_state)
                S_TITLE: begin
                    if (start_btn) begin
                        r_state          <= S_PLAY;
                        r_level          <= '0;
                        r_world          <= '0;
                        r_lives          <= '1;
                        r_screen         <= SCR_PLAY;
                        r_player_disable <= 1'b0;
                        r_reset_select   <= 1'b1;
                        r_audio_enable   <= 1'b0;
                        r_audio_select   <= AUD_NONE;
                    end
                end

                S_PLAY: begin
                    // Release the object-reset pulse after the first play cycle
                    r_reset_select <= 1'b0;
                    if (player_dead) begin
                        // A death takes precedence over a completion in the same cycle
                        r_lives          <= w_lives_dec;
                        r_player_disable <= 1'b1;
                        r_tune           <= 1'b1;
                        r_audio_enable   <= 1'b1;
                        if (w_last_life) begin
                            r_state        <= S_GAMEOVER;
                            r_screen       <= SCR_LOSE;
                            r_audio_select <= AUD_OVER;
                            r_reset_select <= 1'b1;
                        end else begin
                            r_state        <= S_DIED;
                            r_screen       <= SCR_DIED;
                            r_audio_select <= AUD_DEATH;
                        end
                    end else if (w_complete) begin
                        r_player_disable <= 1'b1;
                        r_tune           <= 1'b1;
                        r_audio_enable   <= 1'b1;
                        if (r_level == LAST_LEVEL && r_world == LAST_WORLD) begin
                            r_state        <= S_WIN;
                            r_screen       <= SCR_WIN;
                            r_audio_select <= AUD_WIN;
                            r_reset_select <= 1'b1;
                        end else if (r_level == LAST_LEVEL) begin
                            r_state        <= S_WLD_UP;
                            r_screen       <= SCR_WLD;
                            r_audio_select <= AUD_WORLD;
                        end else begin
                            r_state        <= S_LVL_UP;
                            r_screen       <= SCR_LVL;
                            r_audio_select <= AUD_LEVEL;
                        end
                    end
                end

                default: begin
                    // Event states: continue is only honoured after the tune ends.
                    // A continue in the same cycle as seq_end is therefore dropped.
                    if (r_tune) begin
                        if (seq_end) begin
                            r_tune         <= 1'b0;
                            r_audio_enable <= 1'b0;
                        end
                    end else if (continue_btn) begin
                        r_audio_enable <= 1'b0;
                        r_audio_select <= AUD_NONE;
                        if (r_state == S_GAMEOVER || r_state == S_WIN) begin
                            r_state          <= S_TITLE;
                            r_screen         <= SCR_TITLE;
                            r_player_disable <= 1'b1;
                            r_reset_select   <= 1'b1;
                        end else begin
                            r_state          <= S_PLAY;
                            r_screen         <= SCR_PLAY;
                            r_player_disable <= 1'b0;
                            r_reset_select   <= 1'b1;
                            if (r_state == S_LVL_UP) begin
                                r_level <= r_level + LVL_W'(1);
                            end else if (r_state == S_WLD_UP) begin
                                r_world <= r_world + WLD_W'(1);
                                r_level <= '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign level          = r_level;
    assign world          = r_world;
    assign screen         = r_screen;
    assign lives          = r_lives;
    assign player_disable = r_player_disable;
    assign reset_select   = r_reset_select;
    assign audio_select   = r_audio_select;
    assign audio_enable   = r_audio_enable;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: self-checking bench for game_sequencer.
// Directed scenarios come first, followed by a randomized run.
// The randomized run is checked against an integer-level model of the game rules.
module tb_game_sequencer;

    localparam int NW  = 3;
    localparam int LPW = 4;
    localparam int ML  = 5;
    localparam int LW  = 3;
    localparam int WW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          continue_btn = 1'b0;
    logic          start_btn = 1'b0;
    logic          player_dead = 1'b0;
    logic          level_complete = 1'b0;
    logic          seq_end = 1'b0;
`ifdef GAME_CHEAT_SKIP_EN
    logic          cheat_skip = 1'b0;
`endif
    logic [LW-1:0] level;
    logic [WW-1:0] world;
    logic [2:0]    screen;
    logic [ML-1:0] lives;
    logic          player_disable;
    logic          reset_select;
    logic [2:0]    audio_select;
    logic          audio_enable;

    int n_checks = 0;
    int n_pass   = 0;

    game_sequencer #(
        .NUM_WORLDS(NW), .LEVELS_PER_WORLD(LPW), .MAX_LIVES(ML), .LVL_W(LW), .WLD_W(WW)
    ) dut (
        .clk(clk), .rst(rst), .continue_btn(continue_btn), .start_btn(start_btn),
        .player_dead(player_dead), .level_complete(level_complete), .seq_end(seq_end),
`ifdef GAME_CHEAT_SKIP_EN
        .cheat_skip(cheat_skip),
`endif
        .level(level), .world(world), .screen(screen), .lives(lives),
        .player_disable(player_disable), .reset_select(reset_select),
        .audio_select(audio_select), .audio_enable(audio_enable)
    );

    // Drive one cycle of pulses, then sample 1ns after the edge
    task automatic drive(input logic s, input logic d, input logic c, input logic q, input logic k);
        start_btn = s; player_dead = d; level_complete = c; seq_end = q; continue_btn = k;
        @(posedge clk); #1;
        start_btn = 0; player_dead = 0; level_complete = 0; seq_end = 0; continue_btn = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        // rst wins over a coincident start_btn
        rst = 1'b1; start_btn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_btn = 1'b0;
        $display("reset: screen=%0d lives=%b", screen, lives);
        n_checks++;
        if (screen !== 3'd0 || player_disable !== 1'b1 || reset_select !== 1'b1 ||
            audio_enable !== 1'b0 || audio_select !== 3'd0) begin
            $display("FAIL reset_ctrl: got scr=%0d pd=%b rs=%b ae=%b as=%0d, want 0 1 1 0 0",
                     screen, player_disable, reset_select, audio_enable, audio_select);
        end else n_pass++;
        n_checks++;
        if (lives !== 5'b11111 || level !== 3'd0 || world !== 3'd0) begin
            $display("FAIL reset_counters: got lives=%b lvl=%0d wld=%0d, want 11111 0 0", lives, level, world);
        end else n_pass++;
        drive(0, 1, 1, 1, 1);
        n_checks++;
        if (screen !== 3'd0) $display("FAIL title_ignores: got scr=%0d, want 0", screen);
        else n_pass++;
    endtask

    task automatic test_start();
        drive(1, 0, 0, 0, 0);
        $display("start: screen=%0d lives=%b rs=%b", screen, lives, reset_select);
        n_checks++;
        if (screen !== 3'd1 || lives !== 5'b11111 || reset_select !== 1'b1 || player_disable !== 1'b0) begin
            $display("FAIL start_entry: got scr=%0d lives=%b rs=%b pd=%b, want 1 11111 1 0",
                     screen, lives, reset_select, player_disable);
        end else n_pass++;
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (reset_select !== 1'b0 || screen !== 3'd1) begin
            $display("FAIL start_rs_pulse: got rs=%b scr=%0d, want 0 1", reset_select, screen);
        end else n_pass++;
        drive(1, 0, 0, 1, 1);
        n_checks++;
        if (screen !== 3'd1 || reset_select !== 1'b0 || level !== 3'd0) begin
            $display("FAIL play_ignores: got scr=%0d rs=%b lvl=%0d, want 1 0 0", screen, reset_select, level);
        end else n_pass++;
    endtask

    task automatic test_deaths();
        logic [ML-1:0] full;
        logic [ML-1:0] exp_l;
        full = '1;
        for (int i = 1; i <= ML; i++) begin
            drive(0, 1, 0, 0, 0);
            exp_l = full >> i;
            $display("death %0d: lives=%b screen=%0d as=%0d", i, lives, screen, audio_select);
            n_checks++;
            if (lives !== exp_l) $display("FAIL death_lives: got %b, want %b", lives, exp_l);
            else n_pass++;
            n_checks++;
            if (i < ML) begin
                if (screen !== 3'd6 || audio_select !== 3'd1 || audio_enable !== 1'b1 || player_disable !== 1'b1)
                    $display("FAIL died_screen: got scr=%0d as=%0d ae=%b pd=%b, want 6 1 1 1",
                             screen, audio_select, audio_enable, player_disable);
                else n_pass++;
            end else begin
                if (screen !== 3'd2 || audio_select !== 3'd4 || reset_select !== 1'b1 || audio_enable !== 1'b1)
                    $display("FAIL gameover_screen: got scr=%0d as=%0d rs=%b ae=%b, want 2 4 1 1",
                             screen, audio_select, reset_select, audio_enable);
                else n_pass++;
            end
            drive(0, 0, 0, 1, 0);
            n_checks++;
            if (audio_enable !== 1'b0) $display("FAIL death_seq_end: got ae=%b, want 0", audio_enable);
            else n_pass++;
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (i < ML) begin
                if (screen !== 3'd1 || reset_select !== 1'b1 || player_disable !== 1'b0)
                    $display("FAIL died_continue: got scr=%0d rs=%b pd=%b, want 1 1 0", screen, reset_select, player_disable);
                else n_pass++;
            end else begin
                if (screen !== 3'd0 || reset_select !== 1'b1)
                    $display("FAIL gameover_continue: got scr=%0d rs=%b, want 0 1", screen, reset_select);
                else n_pass++;
            end
        end
    endtask

    task automatic test_world_up();
        do_reset();
        drive(1, 0, 0, 0, 0);
        for (int lv = 0; lv < LPW - 1; lv++) begin
            drive(0, 0, 1, 0, 0);
            $display("level_up at %0d: screen=%0d as=%0d", lv, screen, audio_select);
            n_checks++;
            if (screen !== 3'd4 || audio_select !== 3'd2 || audio_enable !== 1'b1 || level !== LW'(lv))
                $display("FAIL lvl_up_screen: got scr=%0d as=%0d ae=%b lvl=%0d, want 4 2 1 %0d",
                         screen, audio_select, audio_enable, level, lv);
            else n_pass++;
            drive(0, 0, 0, 1, 0);
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (level !== LW'(lv + 1) || screen !== 3'd1 || reset_select !== 1'b1)
                $display("FAIL lvl_up_continue: got lvl=%0d scr=%0d rs=%b, want %0d 1 1", level, screen, reset_select, lv + 1);
            else n_pass++;
            if (lv == 0) begin
                drive(1, 0, 0, 0, 0);
                n_checks++;
                if (level !== 3'd1 || screen !== 3'd1)
                    $display("FAIL start_in_play: got lvl=%0d scr=%0d, want 1 1", level, screen);
                else n_pass++;
            end
        end
        drive(0, 0, 1, 0, 0);
        $display("world_up: screen=%0d as=%0d", screen, audio_select);
        n_checks++;
        if (screen !== 3'd5 || audio_select !== 3'd3 || world !== 3'd0)
            $display("FAIL wld_up_screen: got scr=%0d as=%0d wld=%0d, want 5 3 0", screen, audio_select, world);
        else n_pass++;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (world !== 3'd1 || level !== 3'd0 || screen !== 3'd1)
            $display("FAIL wld_up_continue: got wld=%0d lvl=%0d scr=%0d, want 1 0 1", world, level, screen);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 1, 0, 0);
        $display("dead+complete: screen=%0d level=%0d lives=%b", screen, level, lives);
        n_checks++;
        if (screen !== 3'd6 || level !== 3'd0 || lives !== 5'b01111)
            $display("FAIL dead_priority: got scr=%0d lvl=%0d lives=%b, want 6 0 01111", screen, level, lives);
        else n_pass++;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (screen !== 3'd1 || level !== 3'd0 || world !== 3'd1)
            $display("FAIL dead_priority_after: got scr=%0d lvl=%0d wld=%0d, want 1 0 1", screen, level, world);
        else n_pass++;
    endtask

    task automatic test_continue_early();
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        $display("early continue: screen=%0d ae=%b", screen, audio_enable);
        n_checks++;
        if (screen !== 3'd4 || audio_enable !== 1'b1)
            $display("FAIL continue_in_tune: got scr=%0d ae=%b, want 4 1", screen, audio_enable);
        else n_pass++;
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (screen !== 3'd4 || audio_enable !== 1'b0)
            $display("FAIL continue_with_seq_end: got scr=%0d ae=%b, want 4 0", screen, audio_enable);
        else n_pass++;
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (screen !== 3'd1 || level !== 3'd1)
            $display("FAIL continue_after_tune: got scr=%0d lvl=%0d, want 1 1", screen, level);
        else n_pass++;
        drive(0, 0, 1, 0, 0);
        rst = 1'b1; continue_btn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; continue_btn = 1'b0;
        $display("rst mid-tune: screen=%0d ae=%b", screen, audio_enable);
        n_checks++;
        if (screen !== 3'd0 || audio_enable !== 1'b0 || audio_select !== 3'd0 || level !== 3'd0 ||
            world !== 3'd0 || lives !== 5'b11111 || player_disable !== 1'b1)
            $display("FAIL rst_mid_tune: got scr=%0d ae=%b as=%0d lvl=%0d wld=%0d lives=%b pd=%b",
                     screen, audio_enable, audio_select, level, world, lives, player_disable);
        else n_pass++;
    endtask

    task automatic test_win();
        int exp_scr;
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < NW * LPW; k++) begin
            drive(0, 0, 1, 0, 0);
            exp_scr = (k == NW * LPW - 1) ? 3 : ((k % LPW) == LPW - 1) ? 5 : 4;
            n_checks++;
            if (screen !== 3'(exp_scr))
                $display("FAIL win_path_screen: step %0d got scr=%0d, want %0d", k, screen, exp_scr);
            else n_pass++;
            drive(0, 0, 0, 1, 0);
            if (k == NW * LPW - 1) begin
                $display("win: screen=%0d rs=%b", screen, reset_select);
                n_checks++;
                if (reset_select !== 1'b1 || level !== LW'(LPW - 1) || world !== WW'(NW - 1))
                    $display("FAIL win_hold: got rs=%b lvl=%0d wld=%0d, want 1 %0d %0d", reset_select, level, world, LPW - 1, NW - 1);
                else n_pass++;
            end
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (k == NW * LPW - 1) begin
                if (screen !== 3'd0) $display("FAIL win_continue: got scr=%0d, want 0", screen);
                else n_pass++;
            end else begin
                if (level !== LW'((k + 1) % LPW) || world !== WW'((k + 1) / LPW))
                    $display("FAIL win_path_pos: step %0d got lvl=%0d wld=%0d, want %0d %0d",
                             k, level, world, (k + 1) % LPW, (k + 1) / LPW);
                else n_pass++;
            end
        end
    endtask

`ifdef GAME_CHEAT_SKIP_EN
    task automatic test_cheat();
        do_reset();
        drive(1, 0, 0, 0, 0);
        cheat_skip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        cheat_skip = 1'b0;
        $display("cheat: screen=%0d level=%0d", screen, level);
        n_checks++;
        if (screen !== 3'd4) $display("FAIL cheat_screen: got scr=%0d, want 4", screen);
        else n_pass++;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (level !== 3'd1 || screen !== 3'd1)
            $display("FAIL cheat_one_advance: got lvl=%0d scr=%0d, want 1 1", level, screen);
        else n_pass++;
    endtask
`endif

    // ---------------- reference model for the random run ----------------
    int m_mode;     // 0 title, 1 play, 2 event screen
    int m_evt;      // screen code of the event being shown
    int m_tune;
    int m_lives, m_level, m_world, m_rs_pulse;

    task automatic model_reset();
        m_mode = 0; m_evt = 0; m_tune = 0; m_lives = ML; m_level = 0; m_world = 0; m_rs_pulse = 0;
    endtask

    task automatic model_step(input logic s, input logic d, input logic c, input logic q, input logic k);
        case (m_mode)
            0: if (s) begin
                m_mode = 1; m_level = 0; m_world = 0; m_lives = ML; m_rs_pulse = 1;
            end
            1: begin
                m_rs_pulse = 0;
                if (d) begin
                    m_lives = m_lives - 1;
                    m_evt = (m_lives == 0) ? 2 : 6;
                    m_mode = 2; m_tune = 1;
                end else if (c) begin
                    if (m_level == LPW - 1 && m_world == NW - 1) m_evt = 3;
                    else if (m_level == LPW - 1) m_evt = 5;
                    else m_evt = 4;
                    m_mode = 2; m_tune = 1;
                end
            end
            default: begin
                if (m_tune != 0) begin
                    if (q) m_tune = 0;
                end else if (k) begin
                    if (m_evt == 2 || m_evt == 3) begin
                        m_mode = 0;
                    end else begin
                        if (m_evt == 4) m_level = m_level + 1;
                        if (m_evt == 5) begin m_world = m_world + 1; m_level = 0; end
                        m_mode = 1; m_rs_pulse = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic test_random();
        logic s, d, c, q, k, r;
        logic [ML-1:0] e_lives;
        int e_scr, e_rs, e_as, prev_mode;
        logic [19:0] got, want;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 4) == 0);
            q = ($urandom_range(0, 2) == 0);
            k = ($urandom_range(0, 2) == 0);
            prev_mode = m_mode;
            if (r) model_reset();
            else model_step(s, d, c, q, k);
            rst = r;
            start_btn = s; player_dead = d; level_complete = c; seq_end = q; continue_btn = k;
            @(posedge clk); #1;
            rst = 0; start_btn = 0; player_dead = 0; level_complete = 0; seq_end = 0; continue_btn = 0;
            e_lives = '0;
            for (int i = 0; i < m_lives; i++) e_lives[i] = 1'b1;
            e_scr = (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : m_evt;
            e_rs  = (m_mode == 0) ? 1 : (m_mode == 1) ? m_rs_pulse : ((m_evt == 2 || m_evt == 3) ? 1 : 0);
            e_as  = (m_evt == 6) ? 1 : (m_evt == 4) ? 2 : (m_evt == 5) ? 3 : (m_evt == 2) ? 4 : 5;
            if (m_mode == 2 && prev_mode == 1)
                $display("random cyc %0d: event screen %0d lvl=%0d wld=%0d lives=%0d", cyc, m_evt, m_level, m_world, m_lives);
            got  = {level, world, screen, lives, player_disable, reset_select, audio_enable};
            want = {LW'(m_level), WW'(m_world), 3'(e_scr), e_lives, (m_mode != 1),
                    1'(e_rs), (m_mode == 2 && m_tune != 0)};
            n_checks++;
            if (got !== want)
                $display("FAIL random_outputs: cyc %0d got lvl=%0d wld=%0d scr=%0d lives=%b pd=%b rs=%b ae=%b, want %h (packed %h)",
                         cyc, level, world, screen, lives, player_disable, reset_select, audio_enable, want, got);
            else n_pass++;
            if (m_mode != 2 || m_tune != 0) begin
                n_checks++;
                if (audio_select !== ((m_mode == 2) ? 3'(e_as) : 3'd0))
                    $display("FAIL random_audio: cyc %0d got as=%0d, want %0d", cyc, audio_select,
                             (m_mode == 2) ? e_as : 0);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_deaths();
        test_world_up();
        test_simultaneous();
        test_continue_early();
        test_win();
`ifdef GAME_CHEAT_SKIP_EN
        test_cheat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
